// File: rtl/eater_loader.sv
// Serial program loader: UART 8N1 receiver feeding a framed write into the 16x8 program RAM.
// Optional echo transmitter on tx_o is enabled with `define EATER_LOADER_ECHO_EN.
module eater_loader #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned WORDS        = 16
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       rx_i,
  output logic       mem_we_o,
  output logic [3:0] mem_addr_o,
  output logic [7:0] mem_data_o,
  output logic       cpu_hold_o,
  output logic       done_o,
  output logic       err_o,
  output logic       tx_o
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BitLast  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HalfLast = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    LastAddr = 4'(WORDS - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {FrWaitSync, FrLoad, FrCheck} fr_state_e;

  rx_state_e      rx_state_q;
  logic           rx_meta_q, rx_sync_q, rx_prev_q;
  logic [TW-1:0]  rx_timer_q;
  logic [2:0]     rx_bit_q;
  logic [7:0]     rx_byte_q;
  logic           byte_valid_q, frame_err_q;

  fr_state_e      fr_state_q;
  logic [3:0]     count_q;
  logic [7:0]     sum_q;
  logic           mem_we_q, hold_q, done_q, err_q;
  logic [3:0]     mem_addr_q;
  logic [7:0]     mem_data_q;

`ifdef EATER_LOADER_ECHO_EN
  logic           stat_req_q, stat_ok_q;
`endif

  // Receiver: samples only the synchronized line; rx_prev_q provides the falling-edge detect.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RxIdle;
      rx_timer_q   <= '0;
      rx_bit_q     <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx_i;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RxStart;
            rx_timer_q <= '0;
          end
        end
        RxStart: begin
          if (rx_timer_q == HalfLast) begin
            rx_timer_q <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? RxIdle : RxData;
          end else begin
            rx_timer_q <= rx_timer_q + 1'b1;
          end
        end
        RxData: begin
          if (rx_timer_q == BitLast) begin
            rx_timer_q <= '0;
            rx_byte_q  <= {rx_sync_q, rx_byte_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_timer_q <= rx_timer_q + 1'b1;
          end
        end
        RxStop: begin
          if (rx_timer_q == BitLast) begin
            rx_timer_q   <= '0;
            rx_state_q   <= RxIdle;
            byte_valid_q <= rx_sync_q;
            frame_err_q  <= !rx_sync_q;
          end else begin
            rx_timer_q <= rx_timer_q + 1'b1;
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // Frame sequencer: hold is released only by a frame whose checksum matches.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fr_state_q <= FrWaitSync;
      count_q    <= '0;
      sum_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef EATER_LOADER_ECHO_EN
      stat_req_q <= 1'b0;
      stat_ok_q  <= 1'b0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef EATER_LOADER_ECHO_EN
      stat_req_q <= 1'b0;
`endif
      if (frame_err_q) begin
        err_q <= 1'b1;
`ifdef EATER_LOADER_ECHO_EN
        if (fr_state_q != FrWaitSync) begin
          stat_req_q <= 1'b1;
          stat_ok_q  <= 1'b0;
        end
`endif
        fr_state_q <= FrWaitSync;
      end else if (byte_valid_q) begin
        unique case (fr_state_q)
          FrWaitSync: begin
            if (rx_byte_q == SYNC_BYTE) begin
              hold_q     <= 1'b1;
              err_q      <= 1'b0;
              sum_q      <= '0;
              count_q    <= '0;
              fr_state_q <= FrLoad;
            end
          end
          FrLoad: begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= count_q;
            mem_data_q <= rx_byte_q;
            sum_q      <= sum_q + rx_byte_q;
            if (count_q == LastAddr) begin
              count_q    <= '0;
              fr_state_q <= FrCheck;
            end else begin
              count_q <= count_q + 4'd1;
            end
          end
          FrCheck: begin
            if (rx_byte_q == sum_q) begin
              done_q <= 1'b1;
              hold_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
`ifdef EATER_LOADER_ECHO_EN
            stat_req_q <= 1'b1;
            stat_ok_q  <= (rx_byte_q == sum_q);
`endif
            fr_state_q <= FrWaitSync;
          end
          default: fr_state_q <= FrWaitSync;
        endcase
      end
    end
  end

  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign cpu_hold_o = hold_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

`ifdef EATER_LOADER_ECHO_EN
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  tx_state_e     tx_state_q;
  logic [TW-1:0] tx_timer_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_q;
  logic          ebuf_full_q, stat_pend_q;
  logic [7:0]    ebuf_q, stat_byte_q;

  // Echo byte has priority over the status byte so the checksum echo precedes 06/15.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tx_state_q  <= TxIdle;
      tx_timer_q  <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
      ebuf_full_q <= 1'b0;
      ebuf_q      <= '0;
      stat_pend_q <= 1'b0;
      stat_byte_q <= '0;
    end else begin
      unique case (tx_state_q)
        TxIdle: begin
          if (ebuf_full_q || stat_pend_q) begin
            tx_shift_q <= ebuf_full_q ? ebuf_q : stat_byte_q;
            if (ebuf_full_q) ebuf_full_q <= 1'b0;
            else             stat_pend_q <= 1'b0;
            tx_q       <= 1'b0;
            tx_timer_q <= '0;
            tx_state_q <= TxStart;
          end
        end
        TxStart: begin
          if (tx_timer_q == BitLast) begin
            tx_timer_q <= '0;
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_state_q <= TxData;
          end else begin
            tx_timer_q <= tx_timer_q + 1'b1;
          end
        end
        TxData: begin
          if (tx_timer_q == BitLast) begin
            tx_timer_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= TxStop;
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end else begin
            tx_timer_q <= tx_timer_q + 1'b1;
          end
        end
        TxStop: begin
          if (tx_timer_q == BitLast) begin
            tx_timer_q <= '0;
            tx_state_q <= TxIdle;
          end else begin
            tx_timer_q <= tx_timer_q + 1'b1;
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
      if (byte_valid_q && !ebuf_full_q) begin
        ebuf_q      <= rx_byte_q;
        ebuf_full_q <= 1'b1;
      end
      if (stat_req_q) begin
        stat_pend_q <= 1'b1;
        stat_byte_q <= stat_ok_q ? 8'h06 : 8'h15;
      end
    end
  end

  assign tx_o = tx_q;
`else
  assign tx_o = 1'b1;
`endif

endmodule

// File: tb/tb_eater_loader.sv
// Self-checking bench for eater_loader: frame table, hand-written corner sequences and
// randomized frames checked against a byte-level model of the loader protocol.
module tb_eater_loader;
  localparam int unsigned Cpb = 8;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic       rx_i = 1'b1;
  logic       mem_we_o, cpu_hold_o, done_o, err_o, tx_o;
  logic [3:0] mem_addr_o;
  logic [7:0] mem_data_o;

  eater_loader #(.CLKS_PER_BIT(Cpb), .SYNC_BYTE(8'hA5), .WORDS(16)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .rx_i       (rx_i),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .cpu_hold_o (cpu_hold_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .tx_o       (tx_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Observations taken on the falling edge.
  logic [11:0] obs_q[$];
  int done_cnt = 0, we_nohold = 0, done_hold = 0, tx_bad = 0;

  always @(negedge clk_i) begin
    if (reset_ni) begin
      if (mem_we_o) begin
        obs_q.push_back({mem_addr_o, mem_data_o});
        if (!cpu_hold_o) we_nohold++;
      end
      if (done_o) begin
        done_cnt++;
        if (cpu_hold_o) done_hold++;
      end
    end
`ifndef EATER_LOADER_ECHO_EN
    if (tx_o !== 1'b1) tx_bad++;
`endif
  end

  // Byte-level protocol model: 0 = waiting for sync, 1 = loading, 2 = expecting checksum.
  int          m_mode = 0;
  int          m_cnt = 0;
  logic [7:0]  m_sum = '0;
  bit          m_hold = 0, m_err = 0;
  int          m_done = 0;
  logic [11:0] exp_q[$];

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      m_err  = 1;
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (b == 8'hA5) begin
        m_hold = 1; m_err = 0; m_sum = 0; m_cnt = 0; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      exp_q.push_back({4'(m_cnt), b});
      m_sum = m_sum + b;
      m_cnt++;
      if (m_cnt == 16) m_mode = 2;
    end else begin
      if (b == m_sum) begin
        m_done++;
        m_hold = 0;
      end else begin
        m_err = 1;
      end
      m_mode = 0;
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_sum = 0; m_hold = 0; m_err = 0; m_done = 0;
    exp_q.delete();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok);
    rx_i = 1'b0;
    wait_clk(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_clk(Cpb);
    end
    rx_i = stop_ok;
    wait_clk(Cpb);
    rx_i = 1'b1;
    wait_clk(2);
    model_byte(b, stop_ok);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ".we"},   mem_we_o, 0);
    chk({name, ".addr"}, mem_addr_o, 0);
    chk({name, ".data"}, mem_data_o, 0);
    chk({name, ".hold"}, cpu_hold_o, 0);
    chk({name, ".done"}, done_o, 0);
    chk({name, ".err"},  err_o, 0);
    chk({name, ".tx"},   tx_o, 1);
  endtask

  // Compare observed writes, done pulses and flags against the model, then clear the logs.
  task automatic settle_and_compare(input string name);
    int n;
    wait_clk(40);
    chk({name, ".nwrites"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s.write%0d", name, i), obs_q[i], exp_q[i]);
    chk({name, ".done_cnt"}, done_cnt, m_done);
    chk({name, ".err"}, err_o, m_err);
    chk({name, ".hold"}, cpu_hold_o, m_hold);
    obs_q.delete(); exp_q.delete();
    done_cnt = 0; m_done = 0;
  endtask

  typedef struct {
    string      name;
    logic [7:0] base;
    logic [7:0] step;
    logic [7:0] csum_delta;
    bit         exp_done;
    bit         exp_err;
    bit         exp_hold;
  } frame_vec_t;

  frame_vec_t vecs[6];

  initial begin
    logic [7:0] d, s, junk;
    vecs[0] = '{"good",      8'h00, 8'h01, 8'h00, 1, 0, 0};
    vecs[1] = '{"bad_csum",  8'h00, 8'h01, 8'h01, 0, 1, 1};
    vecs[2] = '{"recover",   8'h00, 8'h01, 8'h00, 1, 0, 0};
    vecs[3] = '{"all_sync",  8'hA5, 8'h00, 8'h00, 1, 0, 0};
    vecs[4] = '{"ff_bad",    8'hFF, 8'h00, 8'h80, 0, 1, 1};
    vecs[5] = '{"step7",     8'h10, 8'h07, 8'h00, 1, 0, 0};

    // Reset idle
    wait_clk(3);
    chk_reset_vals("rst_hold");
    reset_ni = 1'b1;
    wait_clk(1);
    chk_reset_vals("rst_rel");
    wait_clk(1000);
    chk("idle.nwrites", obs_q.size(), 0);
    chk_reset_vals("idle1000");

    // Table of whole frames
    for (int v = 0; v < 6; v++) begin
      s = 8'h00;
      send(8'hA5, 1);
      chk({vecs[v].name, ".hold_after_sync"}, cpu_hold_o, 1);
      for (int k = 0; k < 16; k++) begin
        d = vecs[v].base + 8'(k) * vecs[v].step;
        s = s + d;
        send(d, 1);
      end
      if (v == 0) chk("good.csum_const", s, 8'h78);
      send(s - vecs[v].csum_delta, 1);
      wait_clk(40);
      chk({vecs[v].name, ".tbl_done"}, done_cnt, vecs[v].exp_done);
      chk({vecs[v].name, ".tbl_err"},  err_o, vecs[v].exp_err);
      chk({vecs[v].name, ".tbl_hold"}, cpu_hold_o, vecs[v].exp_hold);
      settle_and_compare(vecs[v].name);
    end

    // Noise and junk: release hold first with a good frame, then glitch and non-sync bytes.
    rx_i = 1'b0;
    wait_clk(2);
    rx_i = 1'b1;
    wait_clk(30);
    send(8'h3C, 1);
    send(8'hFF, 1);
    settle_and_compare("junk");
    chk("junk.hold0", cpu_hold_o, 0);
    chk("junk.err0", err_o, 0);

    // Framing error mid-load, trailing bytes ignored, then a clean frame recovers.
    send(8'hA5, 1);
    for (int k = 0; k < 5; k++) send(8'(k + 1), 1);
    send(8'h55, 0);
    send(8'h11, 1);
    send(8'h22, 1);
    settle_and_compare("frame_err");
    chk("frame_err.err1", err_o, 1);
    chk("frame_err.hold1", cpu_hold_o, 1);
    send(8'hA5, 1);
    s = 0;
    for (int k = 0; k < 16; k++) begin
      send(8'(k * 3), 1);
      s = s + 8'(k * 3);
    end
    send(s, 1);
    settle_and_compare("post_ferr");

    // Reset mid-load, then a full frame must load from address 0.
    send(8'hA5, 1);
    for (int k = 0; k < 8; k++) send(8'h40 + 8'(k), 1);
    reset_ni = 1'b0;
    #1;
    chk_reset_vals("midrst");
    wait_clk(3);
    reset_ni = 1'b1;
    model_reset();
    obs_q.delete();
    done_cnt = 0;
    wait_clk(2);
    chk_reset_vals("midrst_rel");
    send(8'hA5, 1);
    s = 0;
    for (int k = 0; k < 16; k++) begin
      send(8'hC0 + 8'(k), 1);
      s = s + 8'hC0 + 8'(k);
    end
    send(s, 1);
    settle_and_compare("after_rst");

    // Randomized frames: junk, random data, sometimes wrong checksum or framing error.
    for (int f = 0; f < 5; f++) begin
      for (int j = 0; j < int'($urandom_range(2)); j++) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send(junk, 1);
      end
      send(8'hA5, 1);
      s = 0;
      for (int k = 0; k < 16; k++) begin
        d = 8'($urandom);
        s = s + d;
        send(d, ($urandom_range(31) != 0));
      end
      send(($urandom_range(1) != 0) ? s : 8'($urandom), ($urandom_range(15) != 0));
      settle_and_compare($sformatf("rand%0d", f));
    end

    chk("we_without_hold", we_nohold, 0);
    chk("hold_high_at_done", done_hold, 0);
`ifndef EATER_LOADER_ECHO_EN
    chk("tx_idle_high", tx_bad, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
